// File: rtl/immediate_or_src.sv
// Decode-stage register file: one falling-edge write port, two combinational read ports.
// Optional combinational write-to-read forwarding is enabled by defining WRITE_BYPASS_EN.
module immediate_or_src #(
  parameter int          DATA_W   = 16,
  parameter int          ADDR_W   = 3,
  parameter int          NUM_REGS = 8,
  parameter logic [1:0]  IMM_CAT  = 2'b10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] immediate,
  input  logic              write_back,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  input  logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [1:0]        category
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] reg_dst;
  logic [DATA_W-1:0] reg_src;
  logic              imm_sel;

  // Writes land on the falling edge so decode reads see them in the second half of the cycle.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (write_back) begin
      regs[write_addr] <= write_data;
    end
  end

  assign reg_dst = regs[dst_addr];
  assign reg_src = regs[src_addr];
  assign imm_sel = (category == IMM_CAT);

`ifdef WRITE_BYPASS_EN
  logic hit_dst;
  logic hit_src;

  // Forwarding is suppressed during reset so outputs reflect the cleared file.
  assign hit_dst = write_back && rst_n && (write_addr == dst_addr);
  assign hit_src = write_back && rst_n && (write_addr == src_addr);

  always_comb begin
    read_data1 = hit_dst ? write_data : reg_dst;
    read_data2 = reg_src;
    if (imm_sel) begin
      read_data2 = immediate;
    end else if (hit_src) begin
      read_data2 = write_data;
    end
  end
`else
  always_comb begin
    read_data1 = reg_dst;
    read_data2 = imm_sel ? immediate : reg_src;
  end
`endif

endmodule

// File: tb/tb_immediate_or_src.sv
// Self-checking bench for immediate_or_src: directed scenarios plus randomized traffic
// compared against an array-based register file model.
module tb_immediate_or_src;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int NUM_REGS = 8;
  localparam logic [1:0] IMM_CAT = 2'b10;

  logic              clk;
  logic              rst_n;
  logic [DATA_W-1:0] immediate;
  logic              write_back;
  logic [DATA_W-1:0] read_data1;
  logic [DATA_W-1:0] read_data2;
  logic [DATA_W-1:0] write_data;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dst_addr;
  logic [ADDR_W-1:0] write_addr;
  logic [1:0]        category;

  int errors = 0;
  int checks = 0;

  logic [DATA_W-1:0] mdl [NUM_REGS];

  immediate_or_src #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .IMM_CAT(IMM_CAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .immediate(immediate), .write_back(write_back),
    .read_data1(read_data1), .read_data2(read_data2), .write_data(write_data),
    .src_addr(src_addr), .dst_addr(dst_addr), .write_addr(write_addr),
    .category(category)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a plain array updated after each falling edge.
  task automatic model_clear();
    for (int i = 0; i < NUM_REGS; i++) mdl[i] = '0;
  endtask

  task automatic model_write();
    if (write_back && rst_n) mdl[write_addr] = write_data;
  endtask

  function automatic logic [DATA_W-1:0] exp_rd1();
`ifdef WRITE_BYPASS_EN
    if (write_back && rst_n && write_addr == dst_addr) return write_data;
`endif
    return mdl[dst_addr];
  endfunction

  function automatic logic [DATA_W-1:0] exp_rd2();
    if (category == IMM_CAT) return immediate;
`ifdef WRITE_BYPASS_EN
    if (write_back && rst_n && write_addr == src_addr) return write_data;
`endif
    return mdl[src_addr];
  endfunction

  task automatic drive(input logic wb, input logic [DATA_W-1:0] wd, input logic [ADDR_W-1:0] wa,
                       input logic [ADDR_W-1:0] sa, input logic [ADDR_W-1:0] da,
                       input logic [1:0] cat, input logic [DATA_W-1:0] imm);
    write_back = wb; write_data = wd; write_addr = wa;
    src_addr = sa; dst_addr = da; category = cat; immediate = imm;
  endtask

  // Drive at posedge+1, let the falling edge write, settle the model.
  task automatic cycle_write(input logic wb, input logic [DATA_W-1:0] wd, input logic [ADDR_W-1:0] wa,
                             input logic [ADDR_W-1:0] sa, input logic [ADDR_W-1:0] da,
                             input logic [1:0] cat, input logic [DATA_W-1:0] imm);
    @(posedge clk); #1;
    drive(wb, wd, wa, sa, da, cat, imm);
    @(negedge clk);
    model_write();
    #1;
  endtask

  task automatic test_reset();
    drive(1'b0, 16'h0, 3'd0, 3'd3, 3'd4, 2'b00, 16'h1234);
    rst_n = 1'b0;
    model_clear();
    #2;
    checks++;
    if (read_data1 !== 16'h0) begin
      errors++; $display("FAIL reset_rd1 got=%h exp=%h", read_data1, 16'h0);
    end
    checks++;
    if (read_data2 !== 16'h0) begin
      errors++; $display("FAIL reset_rd2 got=%h exp=%h", read_data2, 16'h0);
    end
    category = IMM_CAT; #1;
    checks++;
    if (read_data2 !== 16'h1234) begin
      errors++; $display("FAIL reset_rd2_imm got=%h exp=%h", read_data2, 16'h1234);
    end
    @(posedge clk); #2;
    rst_n = 1'b1;
    category = 2'b00;
  endtask

  task automatic test_directed();
    cycle_write(1'b1, 16'h000E, 3'd4, 3'd3, 3'd4, 2'b10, 16'h0009);
    checks++;
    if (read_data1 !== 16'h000E) begin
      errors++; $display("FAIL dir1_rd1 got=%h exp=%h", read_data1, 16'h000E);
    end
    checks++;
    if (read_data2 !== 16'h0009) begin
      errors++; $display("FAIL dir1_rd2 got=%h exp=%h", read_data2, 16'h0009);
    end
    cycle_write(1'b1, 16'h000F, 3'd3, 3'd3, 3'd4, 2'b00, 16'h000B);
    checks++;
    if (read_data2 !== 16'h000F) begin
      errors++; $display("FAIL dir2_rd2 got=%h exp=%h", read_data2, 16'h000F);
    end
    checks++;
    if (read_data1 !== 16'h000E) begin
      errors++; $display("FAIL dir2_rd1 got=%h exp=%h", read_data1, 16'h000E);
    end
  endtask

  task automatic test_no_write();
    cycle_write(1'b0, 16'h000E, 3'd3, 3'd3, 3'd4, 2'b10, 16'h0001);
    checks++;
    if (read_data2 !== 16'h0001) begin
      errors++; $display("FAIL nowr_rd2_imm got=%h exp=%h", read_data2, 16'h0001);
    end
    checks++;
    if (read_data1 !== 16'h000E) begin
      errors++; $display("FAIL nowr_rd1 got=%h exp=%h", read_data1, 16'h000E);
    end
    category = 2'b00; #1;
    checks++;
    if (read_data2 !== 16'h000F) begin
      errors++; $display("FAIL nowr_r3_kept got=%h exp=%h", read_data2, 16'h000F);
    end
    cycle_write(1'b1, 16'h0001, 3'd2, 3'd2, 3'd4, 2'b00, 16'h0000);
    checks++;
    if (read_data2 !== 16'h0001) begin
      errors++; $display("FAIL r2_rd2 got=%h exp=%h", read_data2, 16'h0001);
    end
    checks++;
    if (read_data1 !== 16'h000E) begin
      errors++; $display("FAIL r2_rd1 got=%h exp=%h", read_data1, 16'h000E);
    end
  endtask

  task automatic test_categories();
    // Only IMM_CAT selects the immediate; the other three codes read the register.
    for (int c = 0; c < 4; c++) begin
      logic [DATA_W-1:0] exp2;
      category = c[1:0];
      immediate = 16'hA5A5;
      src_addr = 3'd3;
      write_back = 1'b0;
      #1;
      exp2 = (c == 2) ? 16'hA5A5 : 16'h000F;
      checks++;
      if (read_data2 !== exp2) begin
        errors++; $display("FAIL cat%0d_rd2 got=%h exp=%h", c, read_data2, exp2);
      end
    end
  endtask

  task automatic test_same_addr();
    @(posedge clk); #1;
    drive(1'b1, 16'hBEEF, 3'd5, 3'd5, 3'd5, 2'b00, 16'h0);
    #1;
    checks++;
    if (read_data1 !== exp_rd1()) begin
      errors++; $display("FAIL same_pre_rd1 got=%h exp=%h", read_data1, exp_rd1());
    end
    checks++;
    if (read_data2 !== exp_rd2()) begin
      errors++; $display("FAIL same_pre_rd2 got=%h exp=%h", read_data2, exp_rd2());
    end
    @(negedge clk);
    model_write();
    #1;
    checks++;
    if (read_data1 !== 16'hBEEF) begin
      errors++; $display("FAIL same_post_rd1 got=%h exp=%h", read_data1, 16'hBEEF);
    end
  endtask

  task automatic test_r0();
    cycle_write(1'b1, 16'h8001, 3'd0, 3'd0, 3'd0, 2'b01, 16'h0);
    checks++;
    if (read_data1 !== 16'h8001) begin
      errors++; $display("FAIL r0_rd1 got=%h exp=%h", read_data1, 16'h8001);
    end
    checks++;
    if (read_data2 !== 16'h8001) begin
      errors++; $display("FAIL r0_rd2 got=%h exp=%h", read_data2, 16'h8001);
    end
  endtask

  task automatic test_reset_midcycle();
    cycle_write(1'b1, 16'hFFFF, 3'd7, 3'd7, 3'd7, 2'b00, 16'h0);
    checks++;
    if (read_data1 !== 16'hFFFF) begin
      errors++; $display("FAIL r7_written got=%h exp=%h", read_data1, 16'hFFFF);
    end
    // Assert reset between edges with a write still requested across the falling edge.
    @(posedge clk); #2;
    write_data = 16'h1357; write_addr = 3'd6; write_back = 1'b1;
    rst_n = 1'b0;
    model_clear();
    #1;
    checks++;
    if (read_data1 !== 16'h0) begin
      errors++; $display("FAIL r7_async_clear got=%h exp=%h", read_data1, 16'h0);
    end
    @(negedge clk); #1;
    write_back = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    dst_addr = 3'd6; #1;
    checks++;
    if (read_data1 !== 16'h0) begin
      errors++; $display("FAIL write_in_reset_dropped got=%h exp=%h", read_data1, 16'h0);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      @(posedge clk); #1;
      drive(1'($urandom), 16'($urandom), 3'($urandom), 3'($urandom), 3'($urandom),
            2'($urandom), 16'($urandom));
      #1;
      checks++;
      if (read_data1 !== exp_rd1()) begin
        errors++; $display("FAIL rnd_pre_rd1 n=%0d got=%h exp=%h", n, read_data1, exp_rd1());
      end
      checks++;
      if (read_data2 !== exp_rd2()) begin
        errors++; $display("FAIL rnd_pre_rd2 n=%0d got=%h exp=%h", n, read_data2, exp_rd2());
      end
      @(negedge clk);
      model_write();
      #1;
      checks++;
      if (read_data1 !== exp_rd1()) begin
        errors++; $display("FAIL rnd_post_rd1 n=%0d got=%h exp=%h", n, read_data1, exp_rd1());
      end
      checks++;
      if (read_data2 !== exp_rd2()) begin
        errors++; $display("FAIL rnd_post_rd2 n=%0d got=%h exp=%h", n, read_data2, exp_rd2());
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 16'h0, 3'd0, 3'd0, 3'd0, 2'b00, 16'h0);
    model_clear();
    @(posedge clk); #2;
    rst_n = 1'b1;
    test_reset();
    test_directed();
    test_no_write();
    test_categories();
    test_same_addr();
    test_r0();
    test_reset_midcycle();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
